// File: rtl/agc_pkg.sv
// Shared constants and types for the AGC shift controller.
//   SHIFT_W_DEF     default width of the shift amount
//   TARGET_MSB_DEF  default target bit position of the peak's leading one
//   MAX_SHIFT_DEF   default upper clamp on the shift amount
//   HOLD_MS_DEF     default number of ms windows needed before a 1-step decay
//   SAT_POS/SAT_NEG 16-bit signed saturation limits
//   agc_state_e     gain-update FSM state encoding
package agc_pkg;

  localparam int unsigned SHIFT_W_DEF    = 5;
  localparam int unsigned TARGET_MSB_DEF = 13;
  localparam int unsigned MAX_SHIFT_DEF  = 16;
  localparam int unsigned HOLD_MS_DEF    = 8;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_APPLY   = 2'd3
  } agc_state_e;

endpackage

// File: rtl/agc_shift_ctrl_if.sv
// Signal bundle between the AGC shift controller and its environment.
//   ms_in, peak_in        1 ms strobe level and per-ms unsigned peak
//   data_in, data_valid   32-bit signed sample stream
//   data_out, out_valid   16-bit shifted, saturated sample stream
//   shift, sat_flag       applied shift and per-window saturation flag
//   manual_en/shift       manual shift override (only with AGC_MANUAL_EN)
// Modports: slave = controller side, master = environment side.
interface agc_shift_ctrl_if
  import agc_pkg::*;
#(
  parameter int unsigned SHIFT_W = SHIFT_W_DEF
);

  logic               ms_in;
  logic [31:0]        peak_in;
  logic [31:0]        data_in;
  logic               data_valid;
  logic [15:0]        data_out;
  logic               out_valid;
  logic [SHIFT_W-1:0] shift;
  logic               sat_flag;
`ifdef AGC_MANUAL_EN
  logic               manual_en;
  logic [SHIFT_W-1:0] manual_shift;
`endif

  modport slave (
    input  ms_in,
    input  peak_in,
    input  data_in,
    input  data_valid,
`ifdef AGC_MANUAL_EN
    input  manual_en,
    input  manual_shift,
`endif
    output data_out,
    output out_valid,
    output shift,
    output sat_flag
  );

  modport master (
    output ms_in,
    output peak_in,
    output data_in,
    output data_valid,
`ifdef AGC_MANUAL_EN
    output manual_en,
    output manual_shift,
`endif
    input  data_out,
    input  out_valid,
    input  shift,
    input  sat_flag
  );

endinterface

// File: rtl/agc_shift_ctrl_lead_one_32.sv
// 32-bit leading-one priority encoder (combinational).
//   din   input word
//   idx   index of the highest set bit (0 when din is zero)
//   zero  din is all zeros
module lead_one_32 (
  input  logic [31:0] din,
  output logic [4:0]  idx,
  output logic        zero
);

  always_comb begin
    idx  = '0;
    zero = (din == '0);
    // Ascending scan: the last hit is the highest set bit.
    for (int unsigned i = 0; i < 32; i++) begin
      if (din[i]) idx = 5'(i);
    end
  end

endmodule

// File: rtl/agc_shift_ctrl.sv
// AGC shift controller: turns the per-ms peak into a barrel-shift gain
// (immediate attack, HOLD_MS-window decay) and applies it to the sample
// stream with 16-bit saturation.
//   clk, rst  clock and asynchronous active-high reset
//   bus       agc_shift_ctrl_if.slave (ms/peak in, samples in/out, status)
// Optional macro AGC_MANUAL_EN adds a manual shift override.
module agc_shift_ctrl
  import agc_pkg::*;
#(
  parameter int unsigned TARGET_MSB = TARGET_MSB_DEF,
  parameter int unsigned MAX_SHIFT  = MAX_SHIFT_DEF,
  parameter int unsigned HOLD_MS    = HOLD_MS_DEF,
  parameter int unsigned SHIFT_W    = SHIFT_W_DEF
) (
  input logic             clk,
  input logic             rst,
  agc_shift_ctrl_if.slave bus
);

  localparam int unsigned HOLD_W = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
  localparam logic [SHIFT_W-1:0] MAX_SHIFT_V = SHIFT_W'(MAX_SHIFT);
  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_MS - 1);

  agc_state_e         state_q, state_d;
  logic               ms_r1_q, ms_r2_q;
  logic [31:0]        pk_q, pk_d;
  logic [SHIFT_W-1:0] desired_q, desired_d, desired_calc;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [15:0]        data_out_q, data_out_d;
  logic               out_valid_q;
  logic               sat_acc_q, sat_acc_d;
  logic               sat_flag_q, sat_flag_d;

  logic               ms_edge;
  logic [4:0]         lead_idx;
  logic               lead_zero;
  logic [31:0]        diff;
  logic signed [31:0] shifted;
  logic               sat_now;

  assign ms_edge = ms_r1_q & ~ms_r2_q;

  lead_one_32 u_lead (
    .din  (pk_q),
    .idx  (lead_idx),
    .zero (lead_zero)
  );

  always_comb begin
    diff = '0;
    if (!lead_zero && (32'(lead_idx) > 32'(TARGET_MSB)))
      diff = 32'(lead_idx) - 32'(TARGET_MSB);
    if (diff > 32'(MAX_SHIFT))
      diff = 32'(MAX_SHIFT);
    desired_calc = SHIFT_W'(diff);
  end

  always_comb begin
    state_d   = state_q;
    pk_d      = pk_q;
    desired_d = desired_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    unique case (state_q)
      ST_IDLE:    if (ms_edge) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        pk_d    = bus.peak_in;
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        desired_d = desired_calc;
        state_d   = ST_APPLY;
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        if (desired_q > shift_q) begin
          shift_d = desired_q;
          hold_d  = '0;
        end else if (desired_q < shift_q) begin
          if (hold_q == HOLD_LAST) begin
            shift_d = shift_q - 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end else begin
          hold_d = '0;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
`ifdef AGC_MANUAL_EN
    // Manual override wins over any APPLY update in the same cycle.
    if (bus.manual_en) begin
      shift_d = (bus.manual_shift > MAX_SHIFT_V) ? MAX_SHIFT_V : bus.manual_shift;
      hold_d  = '0;
    end
`endif
  end

  always_comb begin
    shifted    = $signed(bus.data_in) >>> shift_q;
    data_out_d = data_out_q;
    sat_now    = 1'b0;
    if (bus.data_valid) begin
      if (shifted > 32'sd32767) begin
        data_out_d = SAT_POS;
        sat_now    = 1'b1;
      end else if (shifted < -32'sd32768) begin
        data_out_d = SAT_NEG;
        sat_now    = 1'b1;
      end else begin
        data_out_d = shifted[15:0];
      end
    end
    // A saturation in the edge cycle belongs to the window that starts there.
    sat_acc_d  = ms_edge ? sat_now : (sat_acc_q | sat_now);
    sat_flag_d = ms_edge ? sat_acc_q : sat_flag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ms_r1_q     <= 1'b0;
      ms_r2_q     <= 1'b0;
      pk_q        <= '0;
      desired_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      sat_acc_q   <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ms_r1_q     <= bus.ms_in;
      ms_r2_q     <= ms_r1_q;
      pk_q        <= pk_d;
      desired_q   <= desired_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      data_out_q  <= data_out_d;
      out_valid_q <= bus.data_valid;
      sat_acc_q   <= sat_acc_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.shift     = shift_q;
  assign bus.sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_agc_shift_ctrl.sv
// Self-checking bench for agc_shift_ctrl with a behavioural gain/sample model.
module tb_agc_shift_ctrl;
  import agc_pkg::*;

  localparam int unsigned TGT  = 13;
  localparam int unsigned MAXS = 16;
  localparam int unsigned HOLD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  agc_shift_ctrl_if #(.SHIFT_W(5)) bus ();

  agc_shift_ctrl #(
    .TARGET_MSB (TGT),
    .MAX_SHIFT  (MAXS),
    .HOLD_MS    (HOLD),
    .SHIFT_W    (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_shift;
  int m_hold;
  bit m_win_sat;
  bit m_sat_flag;

  task automatic m_reset();
    m_shift = 0; m_hold = 0; m_win_sat = 0; m_sat_flag = 0;
  endtask

  function automatic int m_desired(input logic [31:0] peak);
    int lead = 0;
    int d;
    for (int b = 0; b < 32; b++) if (peak[b]) lead = b;
    d = (lead > int'(TGT)) ? lead - int'(TGT) : 0;
    return (d > int'(MAXS)) ? int'(MAXS) : d;
  endfunction

  task automatic m_ms(input logic [31:0] peak);
    int d = m_desired(peak);
    if (d > m_shift) begin m_shift = d; m_hold = 0; end
    else if (d < m_shift) begin
      if (m_hold == int'(HOLD) - 1) begin m_shift = m_shift - 1; m_hold = 0; end
      else m_hold = m_hold + 1;
    end else m_hold = 0;
    m_sat_flag = m_win_sat;
    m_win_sat  = 0;
  endtask

  function automatic logic [15:0] m_out(input logic [31:0] d, input int s, output bit sat);
    longint v = longint'($signed(d));
    v = v >>> s;
    sat = 1'b1;
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    sat = 1'b0;
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Returns one step into the edge cycle.
  task automatic ms_edge(input logic [31:0] peak);
    bus.peak_in = peak;
    bus.ms_in   = 1'b1;
    tick();
    bus.ms_in   = 1'b0;
  endtask

  task automatic ms_window(input logic [31:0] peak);
    ms_edge(peak);
    repeat (5) tick();
    m_ms(peak);
  endtask

  // Drives one sample, returns after it is registered; updates the model window.
  task automatic drive_sample(input logic [31:0] d, output logic [15:0] exp_out);
    bit s;
    exp_out = m_out(d, m_shift, s);
    if (s) m_win_sat = 1'b1;
    bus.data_in    = d;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    m_reset();
    total++; if (bus.shift !== 5'd0) begin bad++; $display("FAIL reset_shift got=%0d exp=0", bus.shift); end
    total++; if (bus.data_out !== 16'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=0000", bus.data_out); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat_flag got=%b exp=0", bus.sat_flag); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_attack();
    ms_edge(32'h0001_0000);
    repeat (3) tick();
    total++; if (bus.shift !== 5'd0) begin bad++; $display("FAIL attack_early got=%0d exp=0", bus.shift); end
    tick();
    total++; if (bus.shift !== 5'd3) begin bad++; $display("FAIL attack_t4 got=%0d exp=3", bus.shift); end
    tick();
    m_ms(32'h0001_0000);
    total++; if (int'(bus.shift) !== m_shift) begin bad++; $display("FAIL attack_model got=%0d exp=%0d", bus.shift, m_shift); end
  endtask

  task automatic test_decay();
    for (int e = 1; e <= 24; e++) begin
      ms_window(32'h0000_1000);
      total++;
      if (int'(bus.shift) !== m_shift) begin bad++; $display("FAIL decay_edge%0d got=%0d exp=%0d", e, bus.shift, m_shift); end
      if (e == 7) begin
        total++; if (bus.shift !== 5'd3) begin bad++; $display("FAIL decay_hold7 got=%0d exp=3", bus.shift); end
      end
      if (e == 8) begin
        total++; if (bus.shift !== 5'd2) begin bad++; $display("FAIL decay_step8 got=%0d exp=2", bus.shift); end
      end
    end
    total++; if (bus.shift !== 5'd0) begin bad++; $display("FAIL decay_final got=%0d exp=0", bus.shift); end
  endtask

  task automatic test_shift_math();
    logic [15:0] e;
    ms_window(32'h0001_0000);
    total++; if (bus.shift !== 5'd3) begin bad++; $display("FAIL math_shift got=%0d exp=3", bus.shift); end
    drive_sample(32'hFFFF_FFF0, e);
    total++; if (bus.data_out !== 16'hFFFE || e !== 16'hFFFE) begin bad++; $display("FAIL math_neg16 got=%h exp=fffe", bus.data_out); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL math_ov_hi got=%b exp=1", bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL math_ov_lo got=%b exp=0", bus.out_valid); end
    total++; if (bus.data_out !== 16'hFFFE) begin bad++; $display("FAIL math_hold got=%h exp=fffe", bus.data_out); end
  endtask

  task automatic test_saturation();
    logic [15:0] e;
    test_reset();
    drive_sample(32'h0001_0000, e);
    total++; if (bus.data_out !== 16'h7FFF) begin bad++; $display("FAIL sat_pos got=%h exp=7fff", bus.data_out); end
    drive_sample(32'hFFFF_0000, e);
    total++; if (bus.data_out !== 16'h8000) begin bad++; $display("FAIL sat_neg got=%h exp=8000", bus.data_out); end
    total++; if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL sat_pre_edge got=%b exp=0", bus.sat_flag); end
    ms_window(32'h0000_1000);
    total++; if (bus.sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag_set got=%b exp=1", bus.sat_flag); end
    ms_window(32'h0000_1000);
    total++; if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL sat_flag_clear got=%b exp=0", bus.sat_flag); end
  endtask

  task automatic test_clamp();
    ms_window(32'hFFFF_FFFF);
    total++; if (bus.shift !== 5'd16) begin bad++; $display("FAIL clamp got=%0d exp=16", bus.shift); end
    for (int e = 1; e <= 8; e++) ms_window(32'h0);
    total++; if (bus.shift !== 5'd15 || m_shift != 15) begin bad++; $display("FAIL zero_decay got=%0d exp=15", bus.shift); end
  endtask

  task automatic test_random();
    logic [31:0] pk, d;
    logic [15:0] e;
    for (int w = 0; w < 30; w++) begin
      for (int s = 0; s < 3; s++) begin
        d = $urandom;
        d = $signed(d) >>> $urandom_range(0, 28);
        drive_sample(d, e);
        total++;
        if (bus.data_out !== e || bus.out_valid !== 1'b1) begin
          bad++; $display("FAIL rand_sample w%0d d=%h got=%h/%b exp=%h/1", w, d, bus.data_out, bus.out_valid, e);
        end
      end
      tick();
      pk = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
      ms_window(pk);
      total++;
      if (int'(bus.shift) !== m_shift || bus.sat_flag !== m_sat_flag) begin
        bad++; $display("FAIL rand_ms w%0d pk=%h got=%0d/%b exp=%0d/%b", w, pk, bus.shift, bus.sat_flag, m_shift, m_sat_flag);
      end
    end
  endtask

  task automatic test_reset_mid_apply();
    test_reset();
    ms_window(32'h0004_0000);
    total++; if (bus.shift !== 5'd5) begin bad++; $display("FAIL mid_pre_shift got=%0d exp=5", bus.shift); end
    bus.data_in    = 32'h7FFF_FFFF;
    bus.data_valid = 1'b1;
    repeat (3) tick();
    ms_edge(32'hFFFF_FFFF);
    repeat (3) tick();
    total++; if (bus.sat_flag !== 1'b1 || bus.shift !== 5'd5) begin bad++; $display("FAIL mid_pre_state got=%b/%0d exp=1/5", bus.sat_flag, bus.shift); end
    rst = 1'b1;
    #1;
    total++;
    if (bus.shift !== 5'd0 || bus.data_out !== 16'h0 || bus.out_valid !== 1'b0 || bus.sat_flag !== 1'b0) begin
      bad++; $display("FAIL mid_async got=%0d/%h/%b/%b exp=0/0000/0/0", bus.shift, bus.data_out, bus.out_valid, bus.sat_flag);
    end
    bus.data_valid = 1'b0;
    tick();
    rst = 1'b0;
    m_reset();
    tick();
    ms_window(32'h0001_0000);
    total++; if (bus.shift !== 5'd3) begin bad++; $display("FAIL mid_restart got=%0d exp=3", bus.shift); end
  endtask

`ifdef AGC_MANUAL_EN
  task automatic test_manual();
    bus.manual_shift = 5'd20;
    bus.manual_en    = 1'b1;
    tick(); tick();
    total++; if (bus.shift !== 5'd16) begin bad++; $display("FAIL manual_clamp got=%0d exp=16", bus.shift); end
    ms_window(32'h0);
    total++; if (bus.shift !== 5'd16) begin bad++; $display("FAIL manual_hold got=%0d exp=16", bus.shift); end
    bus.manual_en = 1'b0;
    m_shift = 16; m_hold = 0;
    ms_window(32'h0);
    total++; if (int'(bus.shift) !== m_shift) begin bad++; $display("FAIL manual_resume got=%0d exp=%0d", bus.shift, m_shift); end
  endtask
`endif

  initial begin
    bus.ms_in      = 1'b0;
    bus.peak_in    = '0;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
`ifdef AGC_MANUAL_EN
    bus.manual_en    = 1'b0;
    bus.manual_shift = '0;
`endif
    test_reset();
    test_attack();
    test_decay();
    test_shift_math();
    test_saturation();
    test_clamp();
    test_random();
    test_reset_mid_apply();
`ifdef AGC_MANUAL_EN
    test_manual();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/agc_shift_ctrl.md
Name: agc_shift_ctrl

Overview:
- Downstream consumer of the per-millisecond 32-bit absolute peak produced by the peak-detector stage.
- Converts that peak into a barrel-shift gain (fast attack, slow decay).
- Applies the gain to the 32-bit signed sample stream, producing a saturated 16-bit output for the packetiser.
- Sits between the DDC output and the 16-bit data framing stage.

Parameters:
- TARGET_MSB, 13: desired bit position of the peak's leading one after shifting.
- MAX_SHIFT, 16: upper clamp on the shift amount (0..31 legal).
- HOLD_MS, 8: consecutive ms windows requiring a lower shift before decay by 1.
- SHIFT_W, 5: width of the shift amount.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ms_in  in  1  1 ms strobe level, synchronous to clk; the same signal that feeds the peak detector.
- peak_in  in  32  unsigned per-ms peak from the peak detector; stable from 1 cycle after the ms rising edge.
- data_in  in  32  signed sample.
- data_valid  in  1  sample qualifier.
- data_out  out  16  signed, shifted, saturated sample.
- out_valid  out  1  data_out qualifier.
- shift  out  SHIFT_W  currently applied shift.
- sat_flag  out  1  sticky-per-ms: any sample saturated in the previous ms window.

Behaviour:
- Reset (async, active-high): all registers 0; data_out=0, out_valid=0, shift=0, sat_flag=0; FSM to IDLE; hold counter 0.
- Edge detect:
  - ms_r1<=ms_in, ms_r2<=ms_r1; edge = ms_r1 & ~ms_r2 (same timing as the peak detector).
  - One edge per ms; a held-high ms_in gives a single edge.
- FSM: IDLE, CAPTURE, COMPUTE, APPLY.
  - IDLE -> CAPTURE on edge (cycle T).
  - CAPTURE (T+1): register peak_in into pk.
  - COMPUTE (T+2):
    - lead = index of highest set bit of pk; lead=0 when pk==0.
    - desired = lead>TARGET_MSB ? lead-TARGET_MSB : 0, clamped to MAX_SHIFT.
  - APPLY (T+3):
    - desired>shift: shift<=desired, hold_cnt<=0 (attack, immediate).
    - desired<shift: hold_cnt++; when hold_cnt reaches HOLD_MS-1, shift<=shift-1 and hold_cnt<=0 (decay, 1 step per HOLD_MS windows).
    - desired==shift: hold_cnt<=0.
    - Return to IDLE.
  - New shift is visible at T+4.
- An edge arriving while not in IDLE is ignored. This cannot happen at normal ms rates.
- Datapath (1-cycle latency):
  - out_valid <= data_valid.
  - On data_valid: t = data_in >>> shift (arithmetic).
    - t > 32767: data_out=0x7FFF.
    - t < -32768: data_out=0x8000.
    - Otherwise data_out=t[15:0].
  - On !data_valid: data_out holds.
  - A shift change takes effect on the first sample registered after the change; never mid-sample.
- sat_flag:
  - An internal accumulator ORs the saturations within a window.
  - On edge: sat_flag<=accumulator, and the accumulator clears.
  - A saturation in the edge cycle itself counts toward the new window.
- Reset asserted mid-FSM aborts the decision; shift returns to 0.

Optional Feature:
- Macro: AGC_MANUAL_EN.
- Defined:
  - Adds ports manual_en (in, 1) and manual_shift (in, SHIFT_W).
  - While manual_en=1: shift <= min(manual_shift, MAX_SHIFT) each cycle, hold_cnt held at 0, and the FSM still runs but APPLY makes no update.
  - On deassertion: automatic control resumes from the manual value at the next APPLY.
- Undefined: ports absent; automatic control only.

Decomposition:
- Package agc_pkg: FSM state encoding (2-bit), SHIFT_W, default TARGET_MSB/MAX_SHIFT/HOLD_MS constants, 16-bit saturation limits 0x7FFF/0x8000.
- Sub-module lead_one_32: combinational 32-bit leading-one priority encoder (5-bit index, zero flag), instantiated in COMPUTE.

Test Plan:
- Attack: reset, peak_in=0x0001_0000, one ms edge -> shift=3 exactly 4 cycles after edge cycle; hold_cnt=0.
- Decay hysteresis: from shift=3, peak_in=0x0000_1000 (desired 0) for 8 edges -> shift stays 3 through edge 7, becomes 2 after edge 8; 16 more edges -> 0.
- Saturation: shift=0; data_in=0x0001_0000 -> data_out=0x7FFF; data_in=0xFFFF_0000 -> data_out=0x8000; sat_flag=1 after next edge, 0 after the following clean window.
- Shift math: shift=3, data_in=0xFFFF_FFF0 (-16) -> data_out=0xFFFE one cycle after data_valid; out_valid tracks data_valid with 1-cycle delay.
- Clamp/zero: peak_in=0xFFFF_FFFF -> shift=16 (MAX_SHIFT); peak_in=0 -> desired 0, decays 1 per 8 ms.
- Async reset mid-APPLY with shift=5 -> shift, data_out, out_valid, sat_flag 0 immediately; next edge restarts normally. With AGC_MANUAL_EN: manual_shift=20 -> shift=16.
